// File: rtl/frame_buf_mem_arb.sv
// Arbitrates one memory command port between the frame buffer write and read requesters.
// Latency: command valid one cycle after the IDLE sample, ready pulse the cycle after acceptance.
// Backpressure: mem_wait holds the command stable; requests are only sampled in IDLE.
module frame_buf_mem_arb #(
    parameter int ADDR_WIDTH = 3,
    parameter int BURST_MAX  = 4,
    parameter int CNT_W      = $clog2(BURST_MAX + 1)
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  wr_req_l,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic                  rd_req_l,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  mem_wait,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  wr_rdy,
    output logic                  rd_rdy,
    output logic                  grant_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    grant_rd_nxt;
    logic                    mem_write_nxt, mem_read_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
    logic                    wr_rdy_nxt, rd_rdy_nxt;
    logic                    wr_req, rd_req;
    logic                    grant_vld, pick_rd;

    assign wr_req = ~wr_req_l;
    assign rd_req = ~rd_req_l;

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_rd  <= 1'b1;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            wr_rdy    <= 1'b0;
            rd_rdy    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            grant_rd  <= grant_rd_nxt;
            mem_write <= mem_write_nxt;
            mem_read  <= mem_read_nxt;
            mem_addr  <= mem_addr_nxt;
            wr_rdy    <= wr_rdy_nxt;
            rd_rdy    <= rd_rdy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        grant_rd_nxt  = grant_rd;
        mem_write_nxt = mem_write;
        mem_read_nxt  = mem_read;
        mem_addr_nxt  = mem_addr;
        wr_rdy_nxt    = 1'b0;
        rd_rdy_nxt    = 1'b0;
        grant_vld     = 1'b0;
        pick_rd       = 1'b0;

        case (state)
            IDLE: begin
                if (wr_req && rd_req) begin
                    grant_vld = 1'b1;
                    // cnt == 0 means no grant since reset, so the tie goes away from grant_rd (write)
                    if (cnt != '0 && cnt < CNT_MAX)
                        pick_rd = grant_rd;
                    else
                        pick_rd = ~grant_rd;
                end else if (rd_req) begin
                    grant_vld = 1'b1;
                    pick_rd   = 1'b1;
                end else if (wr_req) begin
                    grant_vld = 1'b1;
                    pick_rd   = 1'b0;
                end

                if (grant_vld) begin
                    state_nxt     = ISSUE;
                    mem_addr_nxt  = pick_rd ? rd_req_addr : wr_req_addr;
                    mem_write_nxt = ~pick_rd;
                    mem_read_nxt  = pick_rd;
                    grant_rd_nxt  = pick_rd;
                    if (pick_rd == grant_rd)
                        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    else
                        cnt_nxt = CNT_ONE;
                end
            end
            ISSUE: begin
                if (!mem_wait) begin
                    state_nxt     = ACK;
                    mem_write_nxt = 1'b0;
                    mem_read_nxt  = 1'b0;
                    wr_rdy_nxt    = ~grant_rd;
                    rd_rdy_nxt    = grant_rd;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
